// File: rtl/riscv_lsu_apb_if.sv
// Core-request, response and APB4 signal bundle for the load/store unit.
// master = the LSU itself; slave = the core plus the APB slave around it.
interface riscv_lsu_apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic                  req_wnr_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic                  rsp_valid_o;
  logic [DATA_W-1:0]     rsp_data_o;
  logic                  rsp_err_o;
  logic                  rsp_misalign_o;
  logic                  rsp_timeout_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_W-1:0]     paddr_o;
  logic [DATA_W-1:0]     pwdata_o;
  logic [DATA_W/8-1:0]   pstrb_o;
  logic                  pready_i;
  logic                  pslverr_i;
  logic [DATA_W-1:0]     prdata_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_wnr_i, req_size_i, req_unsigned_i,
    input  pready_i, pslverr_i, prdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_misalign_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_wnr_i, req_size_i, req_unsigned_i,
    output pready_i, pslverr_i, prdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_misalign_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/riscv_lsu_apb.sv
// Load/store unit: one core request becomes one APB4 transfer; 3 cycles + wait states (1 if misaligned).
// Backpressure: req_ready_o is low from acceptance until the response cycle has passed.
module riscv_lsu_apb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  riscv_lsu_apb_if.master bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [NB-1:0]       pstrb_q;
  logic                rsp_valid_q, rsp_err_q, rsp_misalign_q, rsp_timeout_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q;
  logic                unsigned_q;

  logic [ADDR_W-1:0]   paddr_d;
  logic [3:0]          nbytes_d;
  logic [2:0]          amask_d;
  logic                bad_d;
  logic [NB-1:0]       pstrb_d;
  logic [DATA_W-1:0]   pwdata_d;

  always_comb begin
    off_d    = bus.req_addr_i[OFF_W-1:0];
    paddr_d  = bus.req_addr_i & ~ADDR_W'(NB - 1);
    nbytes_d = 4'd1 << bus.req_size_i;
    case (bus.req_size_i)
      2'b00:   amask_d = 3'b000;
      2'b01:   amask_d = 3'b001;
      2'b10:   amask_d = 3'b011;
      default: amask_d = 3'b111;
    endcase
    bad_d = (|(bus.req_addr_i[2:0] & amask_d)) || (DATA_W == 32 && bus.req_size_i == 2'b11);
    pstrb_d = bus.req_wnr_i ? ((~({NB{1'b1}} << nbytes_d)) << off_d) : '0;
    // Store lane is replicated so the slave sees it on every byte lane it might decode.
    case (bus.req_size_i)
      2'b00:   pwdata_d = {NB{bus.req_wdata_i[7:0]}};
      2'b01:   pwdata_d = {(NB/2){bus.req_wdata_i[15:0]}};
      2'b10:   pwdata_d = {(NB/4){bus.req_wdata_i[31:0]}};
      default: pwdata_d = bus.req_wdata_i;
    endcase
  end

  logic [DATA_W-1:0]   lane_d, keep_d, ext_d;
  logic [6:0]          lbits_d;
  logic                sign_d;

  always_comb begin
    lane_d  = bus.prdata_i >> {off_q, 3'b000};
    lbits_d = 7'd8 << size_q;
    keep_d  = ~({DATA_W{1'b1}} << lbits_d);
    case (size_q)
      2'b00:   sign_d = lane_d[7];
      2'b01:   sign_d = lane_d[15];
      2'b10:   sign_d = lane_d[31];
      default: sign_d = lane_d[DATA_W-1];
    endcase
    ext_d = (lane_d & keep_d) | ((sign_d && !unsigned_q) ? ~keep_d : '0);
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      pstrb_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      cnt_q          <= '0;
      off_q          <= '0;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
    end else begin
      // Response outputs live for exactly the RESP cycle.
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            off_q       <= off_d;
            size_q      <= bus.req_size_i;
            unsigned_q  <= bus.req_unsigned_i;
            req_ready_q <= 1'b0;
            if (bad_d) begin
              state_q        <= RESP;
              rsp_valid_q    <= 1'b1;
              rsp_err_q      <= 1'b1;
              rsp_misalign_q <= 1'b1;
            end else begin
              state_q  <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= bus.req_wnr_i;
              paddr_q  <= paddr_d;
              pwdata_q <= pwdata_d;
              pstrb_q  <= pstrb_d;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready_i || (TIMEOUT > 0 && cnt_d == CNT_W'(TIMEOUT))) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b1;
            if (bus.pready_i) begin
              rsp_err_q  <= bus.pslverr_i;
              rsp_data_q <= (bus.pslverr_i || pwrite_q) ? '0 : ext_d;
            end else begin
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o    = req_ready_q;
  assign bus.psel_o         = psel_q;
  assign bus.penable_o      = penable_q;
  assign bus.pwrite_o       = pwrite_q;
  assign bus.paddr_o        = paddr_q;
  assign bus.pwdata_o       = pwdata_q;
  assign bus.pstrb_o        = pstrb_q;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.rsp_misalign_o = rsp_misalign_q;
  assign bus.rsp_timeout_o  = rsp_timeout_q;
endmodule

// File: tb/tb_riscv_lsu_apb.sv
// Bench for riscv_lsu_apb: 32-bit and 64-bit instances share one stimulus path selected by sel64.
// Expected responses are queued at issue and checked by an independent monitor.
module tb_riscv_lsu_apb;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  riscv_lsu_apb_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
  riscv_lsu_apb_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

  riscv_lsu_apb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u32 (.clk(clk), .reset(rst_n), .bus(b32));
  riscv_lsu_apb #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) u64 (.clk(clk), .reset(rst_n), .bus(b64));

  bit          sel64;
  logic        s_valid, s_wnr, s_uns, s_pready, s_pslverr;
  logic [31:0] s_addr;
  logic [63:0] s_wdata, s_prdata;
  logic [1:0]  s_size;

  always_comb begin
    b32.req_valid_i = s_valid & ~sel64;  b64.req_valid_i = s_valid & sel64;
    b32.req_addr_i  = s_addr;            b64.req_addr_i  = s_addr;
    b32.req_wdata_i = s_wdata[31:0];     b64.req_wdata_i = s_wdata;
    b32.req_wnr_i   = s_wnr;             b64.req_wnr_i   = s_wnr;
    b32.req_size_i  = s_size;            b64.req_size_i  = s_size;
    b32.req_unsigned_i = s_uns;          b64.req_unsigned_i = s_uns;
    b32.pready_i    = s_pready;          b64.pready_i    = s_pready;
    b32.pslverr_i   = s_pslverr;         b64.pslverr_i   = s_pslverr;
    b32.prdata_i    = s_prdata[31:0];    b64.prdata_i    = s_prdata;
  end

  logic        m_ready, m_rsp_valid, m_err, m_mis, m_to, m_psel, m_pen, m_pwrite;
  logic [63:0] m_rsp_data, m_pwdata;
  logic [31:0] m_paddr;
  logic [7:0]  m_pstrb;

  always_comb begin
    m_ready     = sel64 ? b64.req_ready_o    : b32.req_ready_o;
    m_rsp_valid = sel64 ? b64.rsp_valid_o    : b32.rsp_valid_o;
    m_err       = sel64 ? b64.rsp_err_o      : b32.rsp_err_o;
    m_mis       = sel64 ? b64.rsp_misalign_o : b32.rsp_misalign_o;
    m_to        = sel64 ? b64.rsp_timeout_o  : b32.rsp_timeout_o;
    m_psel      = sel64 ? b64.psel_o         : b32.psel_o;
    m_pen       = sel64 ? b64.penable_o      : b32.penable_o;
    m_pwrite    = sel64 ? b64.pwrite_o       : b32.pwrite_o;
    m_paddr     = sel64 ? b64.paddr_o        : b32.paddr_o;
    m_rsp_data  = sel64 ? b64.rsp_data_o     : {32'h0, b32.rsp_data_o};
    m_pwdata    = sel64 ? b64.pwdata_o       : {32'h0, b32.pwdata_o};
    m_pstrb     = sel64 ? b64.pstrb_o        : {4'h0, b32.pstrb_o};
  end

  typedef struct {
    logic [63:0] data;
    bit          err, mis, tmo, apb, pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    int          lat, nacc, exp_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks, errors, n_rsp, cyc, cur_waits;
  bit   mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: what the access means in bytes, not how the RTL builds it.
  function automatic exp_t model(input logic [31:0] addr, input logic [63:0] wdata, input bit wnr,
                                 input logic [1:0] size, input bit uns, input int waits,
                                 input bit slverr, input logic [63:0] prdata, input bit w64);
    exp_t e;
    int nb, bits, nbus, off;
    logic [63:0] lane, mask, busmask;
    nbus    = w64 ? 8 : 4;
    nb      = 1 << size;
    bits    = 8 * nb;
    off     = int'(addr % nbus);
    busmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mask    = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    e = '{default: 0};
    if ((size == 2'b11 && !w64) || (addr % nb) != 0) begin
      e.err = 1; e.mis = 1; e.lat = 1;
      return e;
    end
    e.apb    = 1;
    e.paddr  = addr - 32'(off);
    e.pwrite = wnr;
    e.pstrb  = wnr ? 8'(((1 << nb) - 1) << off) : 8'h0;
    lane = wdata & mask;
    for (int k = 0; k < nbus / nb; k++) e.pwdata = e.pwdata | (lane << (k * bits));
    if (waits >= TO) begin
      e.err = 1; e.tmo = 1; e.lat = 2 + TO; e.nacc = TO;
      return e;
    end
    e.lat  = 3 + waits;
    e.nacc = waits + 1;
    if (slverr) e.err = 1;
    else if (!wnr) begin
      lane = ((prdata & busmask) >> (8 * off)) & mask;
      if (!uns && ((lane >> (bits - 1)) & 64'd1) != 64'd0) lane = lane | ~mask;
      e.data = lane & busmask;
    end
    return e;
  endfunction

  // APB slave: pready low for cur_waits ACCESS cycles, then high.
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(negedge clk);
      if (m_psel && m_pen) begin
        s_pready = (acc >= cur_waits);
        acc++;
      end else begin
        acc = 0;
        s_pready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int acc;
    exp_t e;
    acc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (!rst_n) begin acc = 0; continue; end
      if (m_psel) begin
        checks++;
        if (sb_q.size() == 0 || !sb_q[0].apb) begin
          errors++;
          $display("FAIL apb_unexpected psel=1 paddr=%h required no APB activity", m_paddr);
        end else if ({m_paddr, m_pwdata, m_pstrb, m_pwrite} !==
                     {sb_q[0].paddr, sb_q[0].pwdata, sb_q[0].pstrb, sb_q[0].pwrite}) begin
          errors++;
          $display("FAIL apb_fields got paddr=%h pwdata=%h pstrb=%h pwrite=%b want paddr=%h pwdata=%h pstrb=%h pwrite=%b",
                   m_paddr, m_pwdata, m_pstrb, m_pwrite, sb_q[0].paddr, sb_q[0].pwdata, sb_q[0].pstrb, sb_q[0].pwrite);
        end
        if (m_pen) acc++;
      end
      if (m_rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected data=%h err=%b with nothing outstanding", m_rsp_data, m_err);
        end else begin
          e = sb_q.pop_front();
          if ({m_ready, m_rsp_data, m_err, m_mis, m_to} !== {1'b0, e.data, e.err, e.mis, e.tmo}) begin
            errors++;
            $display("FAIL rsp got rdy=%b data=%h err=%b mis=%b to=%b want rdy=0 data=%h err=%b mis=%b to=%b",
                     m_ready, m_rsp_data, m_err, m_mis, m_to, e.data, e.err, e.mis, e.tmo);
          end
          checks++;
          if (cyc + 1 != e.exp_cyc) begin
            errors++;
            $display("FAIL rsp_latency got cycle %0d want %0d", cyc + 1, e.exp_cyc);
          end
          checks++;
          if (acc != e.nacc) begin
            errors++;
            $display("FAIL access_cycles got %0d want %0d", acc, e.nacc);
          end
          n_rsp++;
        end
        acc = 0;
      end else if (sb_q.size() == 0) begin
        checks++;
        if ({m_ready, m_psel, m_pen, m_pwrite, m_err, m_mis, m_to} !== 7'b1000000 ||
            m_paddr !== 32'h0 || m_pwdata !== 64'h0 || m_pstrb !== 8'h0 || m_rsp_data !== 64'h0) begin
          errors++;
          $display("FAIL idle_outputs got rdy=%b psel=%b pen=%b pwrite=%b paddr=%h pstrb=%h err=%b want rdy=1 and all else 0",
                   m_ready, m_psel, m_pen, m_pwrite, m_paddr, m_pstrb, m_err);
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    checks++;
    if ({m_psel, m_pen, m_rsp_valid, m_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL %s got psel=%b pen=%b rsp_valid=%b rdy=%b want psel=0 pen=0 rsp_valid=0 rdy=1",
               name, m_psel, m_pen, m_rsp_valid, m_ready);
    end
  endtask

  task automatic run_req(input logic [31:0] addr, input logic [63:0] wdata, input bit wnr,
                         input logic [1:0] size, input bit uns, input int waits, input bit slverr,
                         input logic [63:0] prdata, input bit mid_reset);
    exp_t e;
    int n0;
    bit done;
    e = model(addr, wdata, wnr, size, uns, waits, slverr, prdata, sel64);
    @(negedge clk);
    cur_waits = waits; s_pslverr = slverr; s_prdata = prdata;
    n0 = n_rsp;
    sb_q.push_back(e);
    s_valid = 1'b1; s_addr = addr; s_wdata = wdata; s_wnr = wnr; s_size = size; s_uns = uns;
    for (int i = 0; i < 50; i++) begin
      if (m_ready) break;
      @(negedge clk);
    end
    checks++;
    if (!m_ready) begin
      errors++;
      $display("FAIL accept got req_ready=0 for 50 cycles want 1");
      s_valid = 1'b0;
      sb_q.delete();
      return;
    end
    sb_q[$].exp_cyc = cyc + 1 + e.lat;
    @(negedge clk);
    s_valid = 1'b0; s_addr = $urandom; s_wdata = {$urandom, $urandom}; s_size = 2'($urandom_range(0, 3));
    if (mid_reset) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("reset_mid_access");
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    done = 0;
    for (int i = 0; i < e.lat + 10; i++) begin
      @(negedge clk);
      if (n_rsp != n0) begin done = 1; break; end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got no response within %0d cycles want one response", e.lat + 10);
      sb_q.delete();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic random_burst(input int n);
    logic [1:0]  sz;
    logic [31:0] a;
    int          w;
    for (int i = 0; i < n; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 2));
      run_req(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), w,
              ($urandom_range(0, 9) == 0), {$urandom, $urandom}, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; n_rsp = 0; cyc = 0; cur_waits = 0; mon_en = 0; sel64 = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wnr = 1'b0; s_size = 2'b00;
    s_uns = 1'b0; s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst_n  = 1'b1;
    mon_en = 1;

    run_req(32'h100, 64'h0, 0, 2'b10, 0, 0, 0, 64'hDEADBEEF, 0);
    run_req(32'h103, 64'h0, 0, 2'b00, 0, 0, 0, 64'h80FF0000, 0);
    run_req(32'h103, 64'h0, 0, 2'b00, 1, 0, 0, 64'h80FF0000, 0);
    run_req(32'h202, 64'h1234ABCD, 1, 2'b01, 0, 2, 0, 64'h55AA55AA, 0);
    run_req(32'h101, 64'h0, 0, 2'b10, 0, 0, 0, 64'h0, 0);
    run_req(32'h100, 64'h0, 0, 2'b11, 0, 0, 0, 64'h0, 0);
    run_req(32'h100, 64'h0, 0, 2'b10, 0, 10, 0, 64'h12345678, 0);
    run_req(32'h104, 64'h0, 0, 2'b10, 0, 1, 1, 64'hCAFEF00D, 0);
    run_req(32'h100, 64'h0, 0, 2'b10, 0, 3, 0, 64'h11111111, 1);
    run_req(32'h100, 64'h0, 0, 2'b10, 0, 0, 0, 64'h87654321, 0);
    random_burst(150);

    @(negedge clk);
    sel64 = 1;
    run_req(32'h8, 64'h0123456789ABCDEF, 1, 2'b11, 0, 0, 0, 64'h0, 0);
    run_req(32'h8, 64'h0, 0, 2'b11, 0, 1, 0, 64'hFEDCBA9876543210, 0);
    run_req(32'h106, 64'h0, 0, 2'b01, 0, 0, 0, 64'h8001_0000_0000_0000, 0);
    run_req(32'h104, 64'h0, 0, 2'b10, 1, 0, 0, 64'hF000_0000_0000_0000, 0);
    run_req(32'h10C, 64'h0, 0, 2'b11, 0, 0, 0, 64'h0, 0);
    random_burst(150);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
